regpar_ser: RTL and testbench

Parametrised parallel-in/serial-out shift register with a load handshake and frame tracking; the next generation of the 4-bit parallel-load shift register. Accepts a WIDTH-bit word on a valid/ready handshake, emits it one bit per enabled cycle (LSB- or MSB-first), and flags the last bit of each frame. Sits between a word-wide producer and a bit-serial link or a downstream shift chain.

---
 rtl/regpar_pkg.sv | 16 +
 rtl/regpar_ser_if.sv | 52 +++++
 rtl/regpar_ser_cell.sv | 33 +++
 rtl/regpar_ser.sv | 121 ++++++++++++
 tb/tb_regpar_ser.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/regpar_pkg.sv
// regpar_pkg
// Shared types and helpers for the regpar_ser parallel-in/serial-out shifter.
//   state_t   : control FSM states (IDLE waits for a word, SHIFT emits it)
//   cntWidth  : width of a counter that must hold values 0..width inclusive
package regpar_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/regpar_ser_if.sv
// regpar_ser_if
// Bundles the word-side handshake and the serial-side signals of regpar_ser.
// Optional feature macro: REGPAR_ROTATE_EN adds the rotEN control.
//   D, loadValid      : producer offers a WIDTH-bit word
//   loadReady         : block accepts the word this cycle
//   shiftEN, shiftIn  : advance one bit / bit entering the vacated end
//   rotEN             : (REGPAR_ROTATE_EN only) recirculate the outgoing bit
//   Q, qValid, last   : serial bit, frame-active flag, final-bit flag
//   content, bitsLeft : full register contents, bits of the frame still to go
// Modports: master = producer/consumer side, slave = regpar_ser.
interface regpar_ser_if #(
  parameter int WIDTH = 8
);
  import regpar_pkg::*;

  localparam int CNT_W = cntWidth(WIDTH);

  logic [WIDTH-1:0] D;
  logic             loadValid;
  logic             loadReady;
  logic             shiftEN;
  logic             shiftIn;
  logic             Q;
  logic             qValid;
  logic             last;
  logic [WIDTH-1:0] content;
  logic [CNT_W-1:0] bitsLeft;
`ifdef REGPAR_ROTATE_EN
  logic             rotEN;

  modport master (
    output D, loadValid, shiftEN, shiftIn, rotEN,
    input  loadReady, Q, qValid, last, content, bitsLeft
  );

  modport slave (
    input  D, loadValid, shiftEN, shiftIn, rotEN,
    output loadReady, Q, qValid, last, content, bitsLeft
  );
`else
  modport master (
    output D, loadValid, shiftEN, shiftIn,
    input  loadReady, Q, qValid, last, content, bitsLeft
  );

  modport slave (
    input  D, loadValid, shiftEN, shiftIn,
    output loadReady, Q, qValid, last, content, bitsLeft
  );
`endif

endinterface

// File: rtl/regpar_ser_cell.sv
// regpar_cell
// One bit slice of the shift register: selects between set, parallel load,
// shift and hold, and stores the result.
//   clk, reset : rising-edge clock, asynchronous active-low reset (clears to 0)
//   set        : synchronous force to 1, highest priority after reset
//   load, dIn  : parallel load enable and this slice's bit of the word
//   shift, sIn : shift enable and the bit arriving from the neighbour slice
//   q          : stored bit
module regpar_cell (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic load,
  input  logic shift,
  input  logic dIn,
  input  logic sIn,
  output logic q
);

  // Load beats shift so that a word accepted on the last bit of a frame
  // replaces the register instead of being shifted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= 1'b0;
    else if (set)
      q <= 1'b1;
    else if (load)
      q <= dIn;
    else if (shift)
      q <= sIn;
  end

endmodule

// File: rtl/regpar_ser.sv
// regpar_ser
// Parallel-in/serial-out shift register with a valid/ready load handshake and
// frame tracking. A word accepted on the handshake is emitted one bit per
// shiftEN cycle, LSB-first (MSB_FIRST=0) or MSB-first (MSB_FIRST=1); `last`
// marks the final bit, and a new word may be accepted on that cycle so frames
// run back to back.
// Optional feature macro: REGPAR_ROTATE_EN adds bus.rotEN, which feeds the
// outgoing bit back into the vacated end instead of shiftIn.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   set   : synchronous; content to all ones, frame and any load dropped
//   bus   : regpar_ser_if.slave (handshake, serial and status signals)
module regpar_ser
  import regpar_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         set,
  regpar_ser_if.slave  bus
);

  localparam int               CNT_W = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(WIDTH);

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] bitsLeft;
  logic [WIDTH-1:0] content;
  logic [WIDTH-1:0] shiftVal;
  logic             qBit;
  logic             fillBit;
  logic             lastBit;
  logic             loadReadyInt;
  logic             loadFire;
  logic             shiftFire;

  assign qBit = MSB_FIRST ? content[WIDTH-1] : content[0];

`ifdef REGPAR_ROTATE_EN
  assign fillBit = bus.rotEN ? qBit : bus.shiftIn;
`else
  assign fillBit = bus.shiftIn;
`endif

  // Shifted image of the register: the bit at Q drops out, fillBit enters the
  // opposite end.
  always_comb begin
    shiftVal = content;
    if (MSB_FIRST)
      shiftVal = {content[WIDTH-2:0], fillBit};
    else
      shiftVal = {fillBit, content[WIDTH-1:1]};
  end

  assign lastBit      = (state == SHIFT) && (bitsLeft == CNT_W'(1));
  assign loadReadyInt = (state == IDLE) || (lastBit && bus.shiftEN);
  assign loadFire     = bus.loadValid && loadReadyInt;
  assign shiftFire    = (state == SHIFT) && bus.shiftEN;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    regpar_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .set   (set),
      .load  (loadFire),
      .shift (shiftFire),
      .dIn   (bus.D[i]),
      .sIn   (shiftVal[i]),
      .q     (content[i])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  // FSM next state: a load on the final bit keeps the FSM in SHIFT.
  always_comb begin
    stateNext = state;
    if (set)
      stateNext = IDLE;
    else begin
      case (state)
        IDLE:    if (loadFire) stateNext = SHIFT;
        SHIFT:   if (shiftFire && lastBit && !loadFire) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // FSM outputs; loadReady is the only one that depends on an input.
  always_comb begin
    bus.loadReady = loadReadyInt;
    bus.qValid    = (state == SHIFT);
    bus.last      = lastBit;
  end

  // Remaining-bit counter; saturates at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bitsLeft <= '0;
    else if (set)
      bitsLeft <= '0;
    else if (loadFire)
      bitsLeft <= FULL;
    else if (shiftFire && (bitsLeft != '0))
      bitsLeft <= bitsLeft - CNT_W'(1);
  end

  assign bus.Q        = qBit;
  assign bus.content  = content;
  assign bus.bitsLeft = bitsLeft;

endmodule

// File: tb/tb_regpar_ser.sv
// tb_regpar_ser
// Directed bench for regpar_ser at WIDTH=4: one LSB-first instance (busA) and
// one MSB-first instance (busB). Inputs change on the falling edge and
// outputs are compared 1 time unit later.
// Optional feature macro: REGPAR_ROTATE_EN enables the rotate scenario.
module tb_regpar_ser;

  logic clk;
  logic reset;
  logic setA;
  logic setB;
  int   checks;
  int   errors;

  regpar_ser_if #(.WIDTH(4)) busA ();
  regpar_ser_if #(.WIDTH(4)) busB ();

  regpar_ser #(.WIDTH(4), .MSB_FIRST(1'b0)) dutA (
    .clk   (clk),
    .reset (reset),
    .set   (setA),
    .bus   (busA)
  );

  regpar_ser #(.WIDTH(4), .MSB_FIRST(1'b1)) dutB (
    .clk   (clk),
    .reset (reset),
    .set   (setB),
    .bus   (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs to the selected instance (0 = busA, 1 = busB)
  // on the falling edge, then waits for outputs to settle.
  task automatic applyStimulus(input bit sel, input bit lv, input logic [3:0] d,
                               input bit sh, input bit si, input bit st);
    @(negedge clk);
    if (sel) begin
      busB.loadValid = lv;
      busB.D         = d;
      busB.shiftEN   = sh;
      busB.shiftIn   = si;
      setB           = st;
    end else begin
      busA.loadValid = lv;
      busA.D         = d;
      busA.shiftEN   = sh;
      busA.shiftIn   = si;
      setA           = st;
    end
    #1;
  endtask

  initial begin
    logic [3:0] expQ;
    logic [7:0] expSeq;
    logic [3:0] stallContent [6];
    int         stallBits    [6];
    bit         stallEn      [6];

    checks = 0;
    errors = 0;
    reset  = 1'b0;
    setA   = 1'b0;
    setB   = 1'b0;
    busA.D = '0; busA.loadValid = 1'b0; busA.shiftEN = 1'b0; busA.shiftIn = 1'b0;
    busB.D = '0; busB.loadValid = 1'b0; busB.shiftEN = 1'b0; busB.shiftIn = 1'b0;
`ifdef REGPAR_ROTATE_EN
    busA.rotEN = 1'b0;
    busB.rotEN = 1'b0;
`endif

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst content",   32'(busA.content),   0);
    checkOutput("rst Q",         32'(busA.Q),         0);
    checkOutput("rst qValid",    32'(busA.qValid),    0);
    checkOutput("rst last",      32'(busA.last),      0);
    checkOutput("rst loadReady", 32'(busA.loadReady), 1);
    checkOutput("rst bitsLeft",  32'(busA.bitsLeft),  0);
    @(negedge clk);
    reset = 1'b1;

    // Single frame, LSB first: 1011 -> Q 1,1,0,1
    expQ = 4'b1011;
    applyStimulus(0, 1, 4'b1011, 1, 0, 0);
    checkOutput("t1 idle ready", 32'(busA.loadReady), 1);
    checkOutput("t1 idle qValid", 32'(busA.qValid), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 4'b0000, 1, 0, 0);
      checkOutput($sformatf("t1 Q[%0d]", i), 32'(busA.Q), 32'(expQ[i]));
      checkOutput($sformatf("t1 last[%0d]", i), 32'(busA.last), 32'(i == 3));
      checkOutput($sformatf("t1 bitsLeft[%0d]", i), 32'(busA.bitsLeft), 32'(4 - i));
      checkOutput($sformatf("t1 qValid[%0d]", i), 32'(busA.qValid), 1);
    end
    applyStimulus(0, 0, 4'b0000, 0, 0, 0);
    checkOutput("t1 end content", 32'(busA.content), 0);
    checkOutput("t1 end qValid", 32'(busA.qValid), 0);
    checkOutput("t1 end bitsLeft", 32'(busA.bitsLeft), 0);

    // Back-to-back frames: 0110 then 1001 -> Q 0,1,1,0,1,0,0,1
    expSeq = 8'b1001_0110;
    applyStimulus(0, 1, 4'b0110, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, (i == 3), 4'b1001, 1, 0, 0);
      checkOutput($sformatf("t2 Q[%0d]", i), 32'(busA.Q), 32'(expSeq[i]));
      checkOutput($sformatf("t2 qValid[%0d]", i), 32'(busA.qValid), 1);
      if (i == 3 || i == 7) begin
        checkOutput($sformatf("t2 last[%0d]", i), 32'(busA.last), 1);
        checkOutput($sformatf("t2 ready[%0d]", i), 32'(busA.loadReady), 1);
      end
      if (i == 0)
        checkOutput("t2 busy ready", 32'(busA.loadReady), 0);
    end
    applyStimulus(0, 0, 4'b0000, 0, 0, 0);
    checkOutput("t2 end qValid", 32'(busA.qValid), 0);

    // Stall: shiftEN 1,0,0,1,1,1 on 1100
    stallContent = '{4'b1100, 4'b0110, 4'b0110, 4'b0110, 4'b0011, 4'b0001};
    stallBits    = '{4, 3, 3, 3, 2, 1};
    stallEn      = '{1, 0, 0, 1, 1, 1};
    applyStimulus(0, 1, 4'b1100, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 4'b0000, stallEn[i], 0, 0);
      checkOutput($sformatf("t3 content[%0d]", i), 32'(busA.content), 32'(stallContent[i]));
      checkOutput($sformatf("t3 bitsLeft[%0d]", i), 32'(busA.bitsLeft), 32'(stallBits[i]));
      checkOutput($sformatf("t3 Q[%0d]", i), 32'(busA.Q), 32'(stallContent[i][0]));
    end
    applyStimulus(0, 0, 4'b0000, 0, 0, 0);
    checkOutput("t3 end bitsLeft", 32'(busA.bitsLeft), 0);
    checkOutput("t3 end qValid", 32'(busA.qValid), 0);

    // set with two bits left and a load offered
    applyStimulus(0, 1, 4'b1010, 1, 0, 0);
    applyStimulus(0, 0, 4'b0000, 1, 0, 0);
    applyStimulus(0, 0, 4'b0000, 1, 0, 0);
    applyStimulus(0, 1, 4'b0101, 1, 0, 1);
    checkOutput("t4 pre-set bitsLeft", 32'(busA.bitsLeft), 2);
    applyStimulus(0, 0, 4'b0000, 0, 0, 0);
    checkOutput("t4 set content", 32'(busA.content), 32'hF);
    checkOutput("t4 set bitsLeft", 32'(busA.bitsLeft), 0);
    checkOutput("t4 set qValid", 32'(busA.qValid), 0);
    checkOutput("t4 set ready", 32'(busA.loadReady), 1);

    // Asynchronous reset mid-frame
    applyStimulus(0, 1, 4'b1001, 1, 0, 0);
    applyStimulus(0, 0, 4'b0000, 1, 0, 0);
    applyStimulus(0, 0, 4'b0000, 1, 0, 0);
    checkOutput("t4 mid bitsLeft", 32'(busA.bitsLeft), 3);
    reset = 1'b0;
    #1;
    checkOutput("t4 rst content", 32'(busA.content), 0);
    checkOutput("t4 rst Q", 32'(busA.Q), 0);
    checkOutput("t4 rst qValid", 32'(busA.qValid), 0);
    checkOutput("t4 rst last", 32'(busA.last), 0);
    checkOutput("t4 rst ready", 32'(busA.loadReady), 1);
    checkOutput("t4 rst bitsLeft", 32'(busA.bitsLeft), 0);
    busA.shiftEN = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // MSB first: 1000 with shiftIn=1 -> Q 1,0,0,0, final 1111
    expQ = 4'b0001;
    applyStimulus(1, 1, 4'b1000, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 4'b0000, 1, 1, 0);
      checkOutput($sformatf("t5 Q[%0d]", i), 32'(busB.Q), 32'(expQ[i]));
      checkOutput($sformatf("t5 last[%0d]", i), 32'(busB.last), 32'(i == 3));
    end
    applyStimulus(1, 0, 4'b0000, 0, 1, 0);
    checkOutput("t5 end content", 32'(busB.content), 32'hF);
    checkOutput("t5 end qValid", 32'(busB.qValid), 0);

`ifdef REGPAR_ROTATE_EN
    // Rotate: 1010 with rotEN=1 -> Q 0,1,0,1, content back to 1010
    busA.rotEN = 1'b1;
    expQ = 4'b1010;
    applyStimulus(0, 1, 4'b1010, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 4'b0000, 1, 0, 0);
      checkOutput($sformatf("t6 Q[%0d]", i), 32'(busA.Q), 32'(expQ[i]));
      checkOutput($sformatf("t6 bitsLeft[%0d]", i), 32'(busA.bitsLeft), 32'(4 - i));
    end
    applyStimulus(0, 0, 4'b0000, 0, 0, 0);
    checkOutput("t6 end content", 32'(busA.content), 32'hA);
    checkOutput("t6 end qValid", 32'(busA.qValid), 0);
    busA.rotEN = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
